// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
//
// Shares one AXI read channel (AR/R) between the instruction-fetch port and
// the data-load port of the 5-stage pipeline.
//
// Read-address requests are serialised by a two-state FSM. Data requests win
// over instruction requests. Each requester has its own outstanding-read
// counter, and R beats are routed back by rid. An exception flush (wb_ex)
// marks every instruction read still in flight as stale, and those beats are
// swallowed so the IF stage never sees a pre-flush fetch.
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   wb_ex                flush pulse from WB (exception / ertn)
//   inst_req/addr        instruction read request and address
//   inst_addr_ok         instruction request accepted (1-cycle pulse)
//   inst_data_ok/rdata   instruction read data return
//   data_req/addr/size   load request, address and size (0 byte, 1 half, 2 word)
//   data_addr_ok         load request accepted (1-cycle pulse)
//   data_data_ok/rdata   load data return
//   arid/araddr/arsize/arvalid/arready   AXI read-address channel
//   rid/rdata/rvalid/rready              AXI read-data channel
// -----------------------------------------------------------------------------
module axi_rd_arbiter #(
  parameter logic [3:0] INST_ID   = 4'd0,
  parameter logic [3:0] DATA_ID   = 4'd1,
  parameter int         MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_ex,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready
);

  // Counter width just large enough to hold MAX_OUTST (legal range 1..7).
  localparam int CW = (MAX_OUTST > 3) ? 3 : ((MAX_OUTST > 1) ? 2 : 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_t;

  ar_state_t       state_q, state_d;

  logic [3:0]      arid_q, arid_d;
  logic [31:0]     araddr_q, araddr_d;
  logic [2:0]      arsize_q, arsize_d;

  logic [CW-1:0]   inst_cnt_q, inst_cnt_d;
  logic [CW-1:0]   data_cnt_q, data_cnt_d;
  logic [CW-1:0]   cancel_cnt_q, cancel_cnt_d;

  logic            inst_grant;
  logic            data_grant;
  logic            r_inst;
  logic            r_data;
  logic            inst_swallow;
  logic            inst_deliver;
  logic            inst_dec;
  logic            data_dec;

  // ---------------------------------------------------------------------------
  // Grant selection. Only possible in AR_IDLE, so there is always at least one
  // idle cycle between AR handshakes. A flush blocks an instruction grant in
  // the same cycle, otherwise a fetch from the squashed path could slip out
  // after the cancel count was taken.
  // ---------------------------------------------------------------------------
  always_comb begin
    data_grant = 1'b0;
    inst_grant = 1'b0;
    if (state_q == AR_IDLE) begin
      if (data_req && (data_cnt_q < MAX_CNT)) begin
        data_grant = 1'b1;
      end else if (inst_req && (inst_cnt_q < MAX_CNT) && !wb_ex) begin
        inst_grant = 1'b1;
      end
    end
  end

  assign inst_addr_ok = inst_grant;
  assign data_addr_ok = data_grant;

  // ---------------------------------------------------------------------------
  // R channel routing. rready is tied high, so every rvalid is a handshake.
  // An instruction beat is swallowed while stale reads remain to be drained.
  // ---------------------------------------------------------------------------
  always_comb begin
    r_data       = rvalid && (rid == DATA_ID);
    r_inst       = rvalid && (rid == INST_ID);
    inst_swallow = r_inst && (cancel_cnt_q != '0);
    inst_deliver = r_inst && (cancel_cnt_q == '0);
    // A beat that arrives with nothing outstanding must not wrap the counter.
    inst_dec     = r_inst && (inst_cnt_q != '0);
    data_dec     = r_data && (data_cnt_q != '0);
  end

  assign rready       = 1'b1;
  assign inst_data_ok = inst_deliver;
  assign inst_rdata   = inst_deliver ? rdata : 32'h0;
  assign data_data_ok = r_data;
  assign data_rdata   = r_data ? rdata : 32'h0;

  // ---------------------------------------------------------------------------
  // Outstanding counters. A grant and a matching return in the same cycle
  // cancel out.
  // ---------------------------------------------------------------------------
  always_comb begin
    inst_cnt_d = inst_cnt_q;
    if (inst_grant && !inst_dec) begin
      inst_cnt_d = inst_cnt_q + ONE;
    end else if (!inst_grant && inst_dec) begin
      inst_cnt_d = inst_cnt_q - ONE;
    end

    data_cnt_d = data_cnt_q;
    if (data_grant && !data_dec) begin
      data_cnt_d = data_cnt_q + ONE;
    end else if (!data_grant && data_dec) begin
      data_cnt_d = data_cnt_q - ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Cancel counter. On a flush, every instruction read that will still be
  // outstanding after this edge becomes stale; inst_cnt_d already reflects a
  // beat returning in the flush cycle, and a request still waiting in AR_BUSY
  // was counted at its grant. A later flush simply re-takes the snapshot.
  // ---------------------------------------------------------------------------
  always_comb begin
    cancel_cnt_d = cancel_cnt_q;
    if (wb_ex) begin
      cancel_cnt_d = inst_cnt_d;
    end else if (inst_swallow) begin
      cancel_cnt_d = cancel_cnt_q - ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // AR FSM next state and address-channel payload. The payload is captured on
  // the grant edge and held unchanged for the whole AR_BUSY phase.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    arid_d   = arid_q;
    araddr_d = araddr_q;
    arsize_d = arsize_q;

    unique case (state_q)
      AR_IDLE: begin
        if (data_grant) begin
          arid_d   = DATA_ID;
          araddr_d = data_addr;
          arsize_d = {1'b0, data_size};
          state_d  = AR_BUSY;
        end else if (inst_grant) begin
          arid_d   = INST_ID;
          araddr_d = inst_addr;
          arsize_d = 3'd2;
          state_d  = AR_BUSY;
        end
      end
      AR_BUSY: begin
        if (arready) begin
          state_d = AR_IDLE;
        end
      end
      default: begin
        state_d = AR_IDLE;
      end
    endcase
  end

  assign arvalid = (state_q == AR_BUSY);
  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;

  // ---------------------------------------------------------------------------
  // State registers. Reset is asynchronous so a bus abort mid-handshake drops
  // arvalid immediately rather than at the next edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= AR_IDLE;
      arid_q       <= 4'h0;
      araddr_q     <= 32'h0;
      arsize_q     <= 3'h0;
      inst_cnt_q   <= '0;
      data_cnt_q   <= '0;
      cancel_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      arid_q       <= arid_d;
      araddr_q     <= araddr_d;
      arsize_q     <= arsize_d;
      inst_cnt_q   <= inst_cnt_d;
      data_cnt_q   <= data_cnt_d;
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_arbiter
//
// Self-checking bench for axi_rd_arbiter: a table of single-cycle vectors, a
// few directed multi-cycle sequences, and a randomized run against a
// reference model that tracks outstanding instruction reads as a FIFO of
// stale flags and data reads as a plain count.
// -----------------------------------------------------------------------------
module tb_axi_rd_arbiter;

  localparam logic [3:0]  INST_ID   = 4'd0;
  localparam logic [3:0]  DATA_ID   = 4'd1;
  localparam int          MAX_OUTST = 2;
  localparam logic [31:0] IADDR     = 32'h1c00_0000;
  localparam logic [31:0] DADDR     = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_ex;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [31:0] data_addr;
  logic [1:0]  data_size;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  axi_rd_arbiter #(
    .INST_ID   (INST_ID),
    .DATA_ID   (DATA_ID),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_ex        (wb_ex),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_addr    (data_addr),
    .data_size    (data_size),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .arid         (arid),
    .araddr       (araddr),
    .arsize       (arsize),
    .arvalid      (arvalid),
    .arready      (arready),
    .rid          (rid),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .rready       (rready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        inst_req;
    logic        data_req;
    logic        wb_ex;
    logic [1:0]  data_size;
    logic        rvalid;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        e_iaok;
    logic        e_daok;
    logic        e_iok;
    logic [31:0] e_irdata;
    logic        e_dok;
    logic [31:0] e_drdata;
    logic        e_busy;
    logic [3:0]  e_arid;
    logic [2:0]  e_arsize;
    logic [31:0] e_araddr;
  } vec_t;

  vec_t vecs [12];

  // Reference model state
  bit          m_busy;
  logic [3:0]  m_arid;
  logic [31:0] m_araddr;
  logic [2:0]  m_arsize;
  bit          m_stale [$];
  int          m_data_n;
  // Responder: AR handshakes accepted but not yet answered
  int          s_inst_n;
  int          s_data_n;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    wb_ex     = 1'b0;
    inst_req  = 1'b0;
    inst_addr = IADDR;
    data_req  = 1'b0;
    data_addr = DADDR;
    data_size = 2'd0;
    arready   = 1'b0;
    rid       = 4'd0;
    rdata     = 32'h0;
    rvalid    = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    idleInputs();
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();
    m_busy   = 1'b0;
    m_arid   = 4'd0;
    m_araddr = 32'h0;
    m_arsize = 3'd0;
    m_stale.delete();
    m_data_n = 0;
    s_inst_n = 0;
    s_data_n = 0;
  endtask

  task automatic applyStimulus();
    inst_req  = ($urandom % 100) < 60;
    inst_addr = $urandom;
    data_req  = ($urandom % 100) < 40;
    data_addr = $urandom;
    data_size = 2'($urandom_range(0, 2));
    wb_ex     = ($urandom % 100) < 6;
    arready   = ($urandom % 100) < 60;
    rvalid    = 1'b0;
    rid       = 4'd0;
    rdata     = $urandom;
    if (($urandom % 100) < 45) begin
      if (s_inst_n > 0 && (s_data_n == 0 || ($urandom % 2) == 0)) begin
        rvalid = 1'b1;
        rid    = INST_ID;
        s_inst_n--;
      end else if (s_data_n > 0) begin
        rvalid = 1'b1;
        rid    = DATA_ID;
        s_data_n--;
      end else if (($urandom % 4) == 0) begin
        rvalid = 1'b1;
        rid    = 4'(2 + $urandom_range(0, 13));
      end
    end
  endtask

  // One cycle of the reference model: compare outputs, then advance state.
  task automatic modelCycle();
    bit g_data, g_inst, e_iok, e_dok;
    g_data = !m_busy && data_req && (m_data_n < MAX_OUTST);
    g_inst = !m_busy && !g_data && inst_req && (m_stale.size() < MAX_OUTST) && !wb_ex;
    e_dok  = rvalid && (rid == DATA_ID);
    e_iok  = rvalid && (rid == INST_ID) && !(m_stale.size() > 0 && m_stale[0]);

    checkOutput("rnd data_addr_ok", 32'(data_addr_ok), 32'(g_data));
    checkOutput("rnd inst_addr_ok", 32'(inst_addr_ok), 32'(g_inst));
    checkOutput("rnd arvalid", 32'(arvalid), 32'(m_busy));
    if (m_busy) begin
      checkOutput("rnd arid", 32'(arid), 32'(m_arid));
      checkOutput("rnd araddr", araddr, m_araddr);
      checkOutput("rnd arsize", 32'(arsize), 32'(m_arsize));
    end
    checkOutput("rnd inst_data_ok", 32'(inst_data_ok), 32'(e_iok));
    checkOutput("rnd inst_rdata", inst_rdata, e_iok ? rdata : 32'h0);
    checkOutput("rnd data_data_ok", 32'(data_data_ok), 32'(e_dok));
    checkOutput("rnd data_rdata", data_rdata, e_dok ? rdata : 32'h0);
    checkOutput("rnd rready", 32'(rready), 32'd1);

    if (rvalid && rid == INST_ID && m_stale.size() > 0) void'(m_stale.pop_front());
    if (e_dok && m_data_n > 0) m_data_n--;
    if (wb_ex) begin
      foreach (m_stale[i]) m_stale[i] = 1'b1;
    end
    if (g_inst) m_stale.push_back(1'b0);
    if (g_data) m_data_n++;

    if (m_busy) begin
      if (arready) begin
        if (m_arid == INST_ID) s_inst_n++;
        else s_data_n++;
        m_busy = 1'b0;
      end
    end else if (g_data) begin
      m_busy   = 1'b1;
      m_arid   = DATA_ID;
      m_araddr = data_addr;
      m_arsize = {1'b0, data_size};
    end else if (g_inst) begin
      m_busy   = 1'b1;
      m_arid   = INST_ID;
      m_araddr = inst_addr;
      m_arsize = 3'd2;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idleInputs();

    vecs[0]  = '{0,0,0,2'd0, 0,4'd0,32'h0,        0,0, 0,32'h0,        0,32'h0,        0,4'd0,3'd0,32'h0};
    vecs[1]  = '{1,0,0,2'd0, 0,4'd0,32'h0,        1,0, 0,32'h0,        0,32'h0,        1,4'd0,3'd2,IADDR};
    vecs[2]  = '{0,1,0,2'd0, 0,4'd0,32'h0,        0,1, 0,32'h0,        0,32'h0,        1,4'd1,3'd0,DADDR};
    vecs[3]  = '{1,1,0,2'd1, 0,4'd0,32'h0,        0,1, 0,32'h0,        0,32'h0,        1,4'd1,3'd1,DADDR};
    vecs[4]  = '{1,0,1,2'd0, 0,4'd0,32'h0,        0,0, 0,32'h0,        0,32'h0,        0,4'd0,3'd0,32'h0};
    vecs[5]  = '{0,1,1,2'd2, 0,4'd0,32'h0,        0,1, 0,32'h0,        0,32'h0,        1,4'd1,3'd2,DADDR};
    vecs[6]  = '{0,0,0,2'd0, 1,4'd1,32'hA5A55A5A, 0,0, 0,32'h0,        1,32'hA5A55A5A, 0,4'd0,3'd0,32'h0};
    vecs[7]  = '{0,0,0,2'd0, 1,4'd0,32'h13572468, 0,0, 1,32'h13572468, 0,32'h0,        0,4'd0,3'd0,32'h0};
    vecs[8]  = '{0,0,0,2'd0, 1,4'd7,32'hDEADBEEF, 0,0, 0,32'h0,        0,32'h0,        0,4'd0,3'd0,32'h0};
    vecs[9]  = '{0,0,0,2'd0, 0,4'd1,32'hCAFEF00D, 0,0, 0,32'h0,        0,32'h0,        0,4'd0,3'd0,32'h0};
    vecs[10] = '{0,0,1,2'd0, 1,4'd0,32'h0BADF00D, 0,0, 1,32'h0BADF00D, 0,32'h0,        0,4'd0,3'd0,32'h0};
    vecs[11] = '{1,0,0,2'd0, 1,4'd1,32'h11112222, 1,0, 0,32'h0,        1,32'h11112222, 1,4'd0,3'd2,IADDR};

    // Table vectors, each from a fresh reset
    for (int v = 0; v < 12; v++) begin
      doReset();
      checkOutput($sformatf("vec%0d reset arvalid", v), 32'(arvalid), 32'd0);
      inst_req  = vecs[v].inst_req;
      data_req  = vecs[v].data_req;
      wb_ex     = vecs[v].wb_ex;
      data_size = vecs[v].data_size;
      rvalid    = vecs[v].rvalid;
      rid       = vecs[v].rid;
      rdata     = vecs[v].rdata;
      sample();
      checkOutput($sformatf("vec%0d inst_addr_ok", v), 32'(inst_addr_ok), 32'(vecs[v].e_iaok));
      checkOutput($sformatf("vec%0d data_addr_ok", v), 32'(data_addr_ok), 32'(vecs[v].e_daok));
      checkOutput($sformatf("vec%0d inst_data_ok", v), 32'(inst_data_ok), 32'(vecs[v].e_iok));
      checkOutput($sformatf("vec%0d inst_rdata", v), inst_rdata, vecs[v].e_irdata);
      checkOutput($sformatf("vec%0d data_data_ok", v), 32'(data_data_ok), 32'(vecs[v].e_dok));
      checkOutput($sformatf("vec%0d data_rdata", v), data_rdata, vecs[v].e_drdata);
      nextCycle();
      idleInputs();
      sample();
      checkOutput($sformatf("vec%0d arvalid", v), 32'(arvalid), 32'(vecs[v].e_busy));
      if (vecs[v].e_busy) begin
        checkOutput($sformatf("vec%0d arid", v), 32'(arid), 32'(vecs[v].e_arid));
        checkOutput($sformatf("vec%0d arsize", v), 32'(arsize), 32'(vecs[v].e_arsize));
        checkOutput($sformatf("vec%0d araddr", v), araddr, vecs[v].e_araddr);
      end
    end

    // Single instruction read, arready two cycles after arvalid
    doReset();
    inst_req = 1'b1;
    sample();
    checkOutput("A inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    nextCycle(); inst_req = 1'b0; sample();
    checkOutput("A inst_addr_ok pulse", 32'(inst_addr_ok), 32'd0);
    checkOutput("A arvalid c1", 32'(arvalid), 32'd1);
    checkOutput("A arid", 32'(arid), 32'd0);
    checkOutput("A arsize", 32'(arsize), 32'd2);
    checkOutput("A araddr", araddr, 32'h1c00_0000);
    nextCycle(); sample();
    checkOutput("A arvalid c2", 32'(arvalid), 32'd1);
    nextCycle(); arready = 1'b1; sample();
    checkOutput("A arvalid c3", 32'(arvalid), 32'd1);
    checkOutput("A araddr held", araddr, 32'h1c00_0000);
    nextCycle(); arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h12345678; sample();
    checkOutput("A arvalid done", 32'(arvalid), 32'd0);
    checkOutput("A inst_cnt 1", 32'(dut.inst_cnt_q), 32'd1);
    checkOutput("A inst_data_ok", 32'(inst_data_ok), 32'd1);
    checkOutput("A inst_rdata", inst_rdata, 32'h12345678);
    nextCycle(); rvalid = 1'b0; sample();
    checkOutput("A inst_cnt 0", 32'(dut.inst_cnt_q), 32'd0);
    checkOutput("A inst_rdata idle", inst_rdata, 32'h0);

    // Simultaneous requests: data first, inst two cycles later
    doReset();
    inst_req = 1'b1; inst_addr = IADDR + 32'd4;
    data_req = 1'b1; data_size = 2'd1; data_addr = DADDR; arready = 1'b1;
    sample();
    checkOutput("B data_addr_ok", 32'(data_addr_ok), 32'd1);
    checkOutput("B inst_addr_ok c0", 32'(inst_addr_ok), 32'd0);
    nextCycle(); data_req = 1'b0; sample();
    checkOutput("B arid data", 32'(arid), 32'd1);
    checkOutput("B arsize data", 32'(arsize), 32'd1);
    checkOutput("B araddr data", araddr, DADDR);
    checkOutput("B inst_addr_ok busy", 32'(inst_addr_ok), 32'd0);
    nextCycle(); sample();
    checkOutput("B inst_addr_ok c2", 32'(inst_addr_ok), 32'd1);
    nextCycle(); inst_req = 1'b0; sample();
    checkOutput("B arid inst", 32'(arid), 32'd0);
    checkOutput("B araddr inst", araddr, IADDR + 32'd4);

    // Outstanding limit
    doReset();
    inst_req = 1'b1; arready = 1'b1;
    sample(); checkOutput("C grant1", 32'(inst_addr_ok), 32'd1);
    nextCycle(); sample(); checkOutput("C busy1", 32'(inst_addr_ok), 32'd0);
    nextCycle(); sample(); checkOutput("C grant2", 32'(inst_addr_ok), 32'd1);
    nextCycle(); sample(); checkOutput("C busy2", 32'(inst_addr_ok), 32'd0);
    nextCycle(); sample(); checkOutput("C limit", 32'(inst_addr_ok), 32'd0);
    checkOutput("C inst_cnt 2", 32'(dut.inst_cnt_q), 32'd2);
    nextCycle(); rvalid = 1'b1; rid = 4'd0; rdata = 32'h0000_0C01; sample();
    checkOutput("C limit during R", 32'(inst_addr_ok), 32'd0);
    checkOutput("C inst_data_ok", 32'(inst_data_ok), 32'd1);
    nextCycle(); rvalid = 1'b0; sample();
    checkOutput("C grant3", 32'(inst_addr_ok), 32'd1);
    nextCycle(); inst_req = 1'b0;

    // Flush discard with interleaved data
    doReset();
    inst_req = 1'b1; arready = 1'b1;
    sample(); nextCycle(); sample(); nextCycle(); sample();
    checkOutput("D grant2", 32'(inst_addr_ok), 32'd1);
    nextCycle(); inst_req = 1'b0; sample();
    nextCycle(); wb_ex = 1'b1; data_req = 1'b1; data_size = 2'd2; data_addr = DADDR + 32'd8; sample();
    checkOutput("D data grant in flush", 32'(data_addr_ok), 32'd1);
    nextCycle(); wb_ex = 1'b0; data_req = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'hAAAA0001; sample();
    checkOutput("D cancel 2", 32'(dut.cancel_cnt_q), 32'd2);
    checkOutput("D swallow1 ok", 32'(inst_data_ok), 32'd0);
    checkOutput("D swallow1 rdata", inst_rdata, 32'h0);
    nextCycle(); rid = 4'd1; rdata = 32'hD00D0001; sample();
    checkOutput("D cancel 1", 32'(dut.cancel_cnt_q), 32'd1);
    checkOutput("D data ok", 32'(data_data_ok), 32'd1);
    checkOutput("D data rdata", data_rdata, 32'hD00D0001);
    nextCycle(); rid = 4'd0; rdata = 32'hAAAA0002; sample();
    checkOutput("D cancel still 1", 32'(dut.cancel_cnt_q), 32'd1);
    checkOutput("D swallow2 ok", 32'(inst_data_ok), 32'd0);
    nextCycle(); rvalid = 1'b0; inst_req = 1'b1; sample();
    checkOutput("D cancel 0", 32'(dut.cancel_cnt_q), 32'd0);
    checkOutput("D post-flush grant", 32'(inst_addr_ok), 32'd1);
    nextCycle(); inst_req = 1'b0; sample();
    nextCycle(); rvalid = 1'b1; rid = 4'd0; rdata = 32'hBEEF0003; sample();
    checkOutput("D delivered ok", 32'(inst_data_ok), 32'd1);
    checkOutput("D delivered rdata", inst_rdata, 32'hBEEF0003);
    nextCycle(); rvalid = 1'b0;

    // Flush coincident with the last instruction beat
    doReset();
    inst_req = 1'b1; arready = 1'b1;
    sample(); nextCycle(); inst_req = 1'b0; sample();
    nextCycle(); wb_ex = 1'b1; rvalid = 1'b1; rid = 4'd0; rdata = 32'h5A5A0001; sample();
    checkOutput("E inst_data_ok", 32'(inst_data_ok), 32'd1);
    checkOutput("E inst_rdata", inst_rdata, 32'h5A5A0001);
    nextCycle(); idleInputs(); sample();
    checkOutput("E cancel 0", 32'(dut.cancel_cnt_q), 32'd0);
    checkOutput("E inst_cnt 0", 32'(dut.inst_cnt_q), 32'd0);

    // Reset in the middle of an AR handshake
    doReset();
    inst_req = 1'b1;
    sample(); nextCycle(); inst_req = 1'b0; sample();
    checkOutput("F arvalid before", 32'(arvalid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("F arvalid async", 32'(arvalid), 32'd0);
    checkOutput("F araddr cleared", araddr, 32'h0);
    checkOutput("F inst_cnt cleared", 32'(dut.inst_cnt_q), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    nextCycle(); inst_req = 1'b1; sample();
    checkOutput("F regrant", 32'(inst_addr_ok), 32'd1);
    nextCycle(); inst_req = 1'b0; arready = 1'b1; sample();
    checkOutput("F arvalid regrant", 32'(arvalid), 32'd1);
    nextCycle(); arready = 1'b0;

    // Randomized run against the reference model
    doReset();
    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      sample();
      modelCycle();
      nextCycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
